// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO feeding a UART transmitter through a
// start-strobe / ready handshake.
// Optional status outputs (count, overflow) are built when the macro
// UART_TXBUF_STATUS_EN is defined; the default build omits them.
module uart_tx_buffer #(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_ready
`ifdef UART_TXBUF_STATUS_EN
    ,
    output logic [AW:0] count,
    output logic        overflow
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    state_t      state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic        empty, full, push;

    // Occupancy flags come from registered pointers only, so wr_ready never
    // depends on a same-cycle pop.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push  = wr_valid && !full;
    end

    assign wr_ready = !full;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;

    // Write pointer advances on every accepted byte.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    // Handshake FSM: pop on ready in IDLE, strobe for one cycle in START,
    // then wait in BUSY until the transmitter drops ready so a lingering
    // ready from the previous frame cannot trigger a second pop.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_ready && !empty) begin
                    state_d    = START;
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    tx_data_d  = mem_q[rd_ptr_q[AW-1:0]];
                    tx_start_d = 1'b1;
                end
            end
            START:   state_d = BUSY;
            BUSY:    if (!tx_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Storage is deliberately left out of reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    // Control registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

`ifdef UART_TXBUF_STATUS_EN
    logic overflow_q, overflow_d;

    assign count    = wr_ptr_q - rd_ptr_q;
    assign overflow = overflow_q;

    // Sticky flag for any write attempted while the FIFO was full.
    always_comb begin
        overflow_d = overflow_q || (wr_valid && full);
    end

    // Overflow register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) overflow_q <= 1'b0;
        else     overflow_q <= overflow_d;
    end
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: DEPTH=4, transmitter model with 20-cycle frames.
// Status outputs are checked when UART_TXBUF_STATUS_EN is defined.
module tb_uart_tx_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int FRAME = 20;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] wr_data  = 8'h00;
    logic       wr_valid = 1'b0;
    logic       tx_ready = 1'b1;
    logic       wr_ready;
    logic [7:0] tx_data;
    logic       tx_start;
`ifdef UART_TXBUF_STATUS_EN
    logic [AW:0] count;
    logic        overflow;
`endif

    uart_tx_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_ready (tx_ready)
`ifdef UART_TXBUF_STATUS_EN
        ,
        .count    (count),
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a queue of accepted bytes in order, occupancy as
    // accepted-minus-transmitted, and a sticky overflow bit.
    logic [7:0] exp_q[$];
    int         acc = 0, pops = 0, strobes = 0;
    int         edge_cnt = 0, acc_edge = 0, strobe_edge = 0;
    bit         model_ready = 1'b1, ovf_m = 1'b0, last_accept = 1'b0;
    logic [7:0] last_byte = 8'h00;

    // Transmitter model state.
    int busy_cnt = 0, lag = 0, ack_lag = 0;
    bit hold_low = 1'b0, prev_start = 1'b0;

    // Model write side: a write is taken only if the model says there is room.
    always @(posedge clk) begin
        edge_cnt++;
        last_accept = 1'b0;
        if (rst) begin
            exp_q.delete();
            acc = 0; pops = 0; ovf_m = 1'b0; last_byte = 8'h00; model_ready = 1'b1;
        end else if (wr_valid) begin
            if (model_ready) begin
                exp_q.push_back(wr_data);
                acc++; acc_edge = edge_cnt; last_accept = 1'b1;
            end else begin
                ovf_m = 1'b1;
            end
        end
    end

    // Transmitter + scoreboard, evaluated away from the active edge.
    always @(negedge clk) begin
        if (tx_start) begin
            strobes++; strobe_edge = edge_cnt;
            chk("strobe_when_tx_idle", 32'(busy_cnt != 0 || lag != 0), 0);
            chk("strobe_width", 32'(prev_start), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                last_byte = exp_q.pop_front();
                pops++;
                chk("tx_data", 32'(tx_data), 32'(last_byte));
            end
            lag = ack_lag; busy_cnt = FRAME;
        end else begin
            chk("tx_data_hold", 32'(tx_data), 32'(last_byte));
            if (lag > 0) lag--;
            else if (busy_cnt > 0) busy_cnt--;
        end
        prev_start  = tx_start;
        tx_ready    = !hold_low && (busy_cnt == 0 || lag > 0);
        model_ready = (acc - pops) < DEPTH;
        chk("wr_ready", 32'(wr_ready), 32'(model_ready));
`ifdef UART_TXBUF_STATUS_EN
        chk("count", 32'(count), 32'(acc - pops));
        chk("overflow", 32'(overflow), 32'(ovf_m));
`endif
    end

    task automatic drive(input logic v, input logic [7:0] b);
        @(negedge clk);
        wr_valid = v;
        wr_data  = b;
    endtask

    // Hold a write until it is accepted (bounded).
    task automatic push(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        drive(1'b1, b);
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = last_accept;
        end
        chk("push_accepted", 32'(ok), 1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_tx(input bit hl, input int al);
        @(posedge clk);
        #2;
        hold_low = hl;
        ack_lag  = al;
    endtask

    // Wait until every accepted byte has been sent and the line is idle.
    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            #1;
            done = (exp_q.size() == 0) && busy_cnt == 0 && lag == 0 && !tx_start;
        end
        chk(tag, 32'(done), 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base;
        bit seen;

        // Reset state
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
`ifdef UART_TXBUF_STATUS_EN
        chk("rst_count", 32'(count), 0);
        chk("rst_overflow", 32'(overflow), 0);
`endif

        // Single byte: strobe in the cycle after the pop edge
        wait_cycles(6);
        base = strobes;
        push(8'hA5);
        wait_cycles(4);
        chk("single_latency", 32'(strobe_edge - acc_edge), 1);
        chk("single_strobes", 32'(strobes - base), 1);
        chk("single_wr_ready", 32'(wr_ready), 1);
        drain("single_drain");

        // Burst of six on consecutive cycles: one pops early, fifth fills, sixth drops
        base = strobes;
        for (int b = 1; b <= 6; b++) drive(1'b1, 8'(b));
        drive(1'b0, 8'h00);
        #1;
        chk("burst_full", 32'(wr_ready), 0);
        drain("burst_drain");
        chk("burst_strobes", 32'(strobes - base), 5);

        // Overflow with the transmitter held not-ready
        set_tx(1'b1, 0);
        wait_cycles(2);
        base = strobes;
        for (int b = 0; b < 6; b++) drive(1'b1, 8'(8'h60 + b));
        drive(1'b0, 8'h00);
        #1;
        chk("ovf_wr_ready", 32'(wr_ready), 0);
        chk("ovf_no_strobe", 32'(strobes - base), 0);
`ifdef UART_TXBUF_STATUS_EN
        chk("ovf_count", 32'(count), 4);
        chk("ovf_flag", 32'(overflow), 1);
`endif
        set_tx(1'b0, 0);
        drain("ovf_drain");
        chk("ovf_strobes", 32'(strobes - base), 4);

        // Wrap: ten bytes through a four-deep FIFO
        base = strobes;
        for (int b = 0; b < 10; b++) push(8'(8'h10 + b));
        drain("wrap_drain");
        chk("wrap_strobes", 32'(strobes - base), 10);
`ifdef UART_TXBUF_STATUS_EN
        chk("wrap_count", 32'(count), 0);
`endif

        // Reset mid-frame discards the queue
        base = strobes;
        push(8'h31); push(8'h32); push(8'h33);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = (strobes > base);
        end
        chk("rstmid_first_strobe", 32'(seen), 1);
        wait_cycles(5);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        wait_cycles(60);
        chk("rstmid_no_strobe", 32'(strobes - base), 1);
        chk("rstmid_wr_ready", 32'(wr_ready), 1);
        push(8'h44);
        drain("rstmid_drain");
        chk("rstmid_resume", 32'(strobes - base), 2);

        // Ready lingers high after the strobe: still exactly one pop per frame
        set_tx(1'b0, 3);
        base = strobes;
        push(8'h55); push(8'h56);
        drain("lag_drain");
        chk("lag_strobes", 32'(strobes - base), 2);

        // Randomised traffic
        for (int it = 0; it < 200; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                drive(1'b1, 8'($urandom));
                drive(1'b0, 8'h00);
            end else if (r < 7) begin
                wait_cycles($urandom_range(0, 30));
            end else if (r == 7) begin
                set_tx(hold_low, $urandom_range(0, 3));
            end else if (r == 8) begin
                set_tx(1'b1, ack_lag);
                wait_cycles($urandom_range(1, 25));
                set_tx(1'b0, ack_lag);
            end else begin
                for (int k = 0; k < 3; k++) drive(1'b1, 8'($urandom));
                drive(1'b0, 8'h00);
            end
        end
        set_tx(1'b0, 0);
        drain("rand_drain");
        chk("rand_all_sent", 32'(acc - pops), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
